// File: rtl/bmem_row_sched_if.sv
// bmem_row_sched_if: bundles the requester handshakes, the memory port
// signals and the status outputs of the row scheduler.
//   slave  : the scheduler side (bmem_row_sched)
//   master : the environment side (pixel packer, DoG stage, line memory)
// Requester signals: frame_start, wr_valid/wr_data/wr_ready,
//   rd_valid/rd_row_a/rd_row_b/rd_ready, rd_data_a/b, rd_data_valid, rd_err.
// Status: rows_written, frame_done.
// Memory side: mem_we, mem_addr1, mem_addr2, mem_din driven to the memory;
//   mem_dout1/mem_dout2 returned from the memory's registered read ports.
interface bmem_row_sched_if #(
  parameter int AW = 9,
  parameter int DW = 5120
);
  logic          frame_start;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_row_a;
  logic [AW-1:0] rd_row_b;
  logic          rd_ready;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          rd_data_valid;
  logic          rd_err;
  logic [AW:0]   rows_written;
  logic          frame_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr1;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout1;
  logic [DW-1:0] mem_dout2;

  modport slave (
    input  frame_start, wr_valid, wr_data, rd_valid, rd_row_a, rd_row_b,
           mem_dout1, mem_dout2,
    output wr_ready, rd_ready, rd_data_a, rd_data_b, rd_data_valid, rd_err,
           rows_written, frame_done, mem_we, mem_addr1, mem_addr2, mem_din
  );

  modport master (
    output frame_start, wr_valid, wr_data, rd_valid, rd_row_a, rd_row_b,
           mem_dout1, mem_dout2,
    input  wr_ready, rd_ready, rd_data_a, rd_data_b, rd_data_valid, rd_err,
           rows_written, frame_done, mem_we, mem_addr1, mem_addr2, mem_din
  );
endinterface

// File: rtl/bmem_row_sched.sv
// bmem_row_sched: row scheduler / port arbiter for the dual-port image line
// memory. Sequential row writes and row-pair reads share memory port 1;
// port 2 is read-only. Reads of rows not yet written in the current frame
// stall; out-of-range rows are accepted and flagged with rd_err.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bmem_row_sched_if.slave (handshakes, status, memory port signals)
// wr_ready/rd_ready/mem_we/mem_addr* are combinational from the current
// requests; rd_data_valid/rd_err are registered (memory read latency 1).
module bmem_row_sched #(
  parameter int ROWS = 480,
  parameter int AW   = 9,
  parameter int DW   = 5120
) (
  input logic             clk,
  input logic             rst,
  bmem_row_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [AW:0] ROWS_C   = (AW+1)'(ROWS);
  localparam logic        LG_READ  = 1'b0;
  localparam logic        LG_WRITE = 1'b1;

  state_t        state_r;
  logic [AW:0]   rows_written_r;
  logic          last_grant_r;
  logic [AW-1:0] addr1_r;
  logic [AW-1:0] addr2_r;
  logic          rd_data_valid_r;
  logic          rd_err_r;

  logic          a_oor_s;
  logic          b_oor_s;
  logic          rows_ok_s;
  logic          wr_elig_s;
  logic          rd_elig_s;
  logic          grant_w_s;
  logic          grant_r_s;
  logic [AW:0]   rows_inc_s;
  logic [AW-1:0] addr1_s;
  logic [AW-1:0] addr2_s;

  // Eligibility of each request and round-robin grant of port 1.
  always_comb begin
    a_oor_s    = 1'b0;
    b_oor_s    = 1'b0;
    rows_ok_s  = 1'b0;
    wr_elig_s  = 1'b0;
    rd_elig_s  = 1'b0;
    grant_w_s  = 1'b0;
    grant_r_s  = 1'b0;
    rows_inc_s = rows_written_r + {{AW{1'b0}}, 1'b1};

    a_oor_s   = ({1'b0, bus.rd_row_a} >= ROWS_C);
    b_oor_s   = ({1'b0, bus.rd_row_b} >= ROWS_C);
    rows_ok_s = ({1'b0, bus.rd_row_a} < rows_written_r) &&
                ({1'b0, bus.rd_row_b} < rows_written_r);

    if (bus.frame_start) begin
      wr_elig_s = 1'b0;
      rd_elig_s = 1'b0;
    end else begin
      wr_elig_s = (state_r == FILL) && bus.wr_valid;
      // Out-of-range reads are let through so they can be flagged.
      rd_elig_s = ((state_r == FILL) || (state_r == FULL)) && bus.rd_valid &&
                  (rows_ok_s || a_oor_s || b_oor_s);
    end

    // A lone eligible request always wins; on a tie the side not granted
    // last time goes, so an ineligible request never burns the turn.
    if (wr_elig_s && rd_elig_s) begin
      grant_w_s = (last_grant_r == LG_READ);
      grant_r_s = (last_grant_r == LG_WRITE);
    end else begin
      grant_w_s = wr_elig_s;
      grant_r_s = rd_elig_s;
    end
  end

  // Memory port addresses: follow the granted operation, otherwise hold.
  always_comb begin
    addr1_s = addr1_r;
    addr2_s = addr2_r;
    if (grant_w_s) begin
      addr1_s = rows_written_r[AW-1:0];
    end else if (grant_r_s) begin
      addr1_s = bus.rd_row_a;
      addr2_s = bus.rd_row_b;
    end else begin
      addr1_s = addr1_r;
      addr2_s = addr2_r;
    end
  end

  // Frame FSM, row counter, arbitration history and read-return flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      rows_written_r  <= {(AW+1){1'b0}};
      last_grant_r    <= LG_READ;
      addr1_r         <= {AW{1'b0}};
      addr2_r         <= {AW{1'b0}};
      rd_data_valid_r <= 1'b0;
      rd_err_r        <= 1'b0;
    end else begin
      rd_data_valid_r <= grant_r_s;
      rd_err_r        <= grant_r_s && (a_oor_s || b_oor_s);
      addr1_r         <= addr1_s;
      addr2_r         <= addr2_s;

      if (grant_w_s) begin
        last_grant_r <= LG_WRITE;
      end else if (grant_r_s) begin
        last_grant_r <= LG_READ;
      end else begin
        last_grant_r <= last_grant_r;
      end

      case (state_r)
        IDLE: begin
          if (bus.frame_start) begin
            state_r        <= FILL;
            rows_written_r <= {(AW+1){1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        FILL: begin
          if (bus.frame_start) begin
            state_r        <= FILL;
            rows_written_r <= {(AW+1){1'b0}};
          end else if (grant_w_s) begin
            rows_written_r <= rows_inc_s;
            if (rows_inc_s == ROWS_C) begin
              state_r <= FULL;
            end else begin
              state_r <= FILL;
            end
          end else begin
            state_r <= FILL;
          end
        end
        FULL: begin
          if (bus.frame_start) begin
            state_r        <= FILL;
            rows_written_r <= {(AW+1){1'b0}};
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r        <= IDLE;
          rows_written_r <= {(AW+1){1'b0}};
        end
      endcase
    end
  end

  // The write pointer is the row count: rows are written strictly in order.
  assign bus.wr_ready      = grant_w_s;
  assign bus.rd_ready      = grant_r_s;
  assign bus.mem_we        = grant_w_s;
  assign bus.mem_addr1     = addr1_s;
  assign bus.mem_addr2     = addr2_s;
  assign bus.mem_din       = bus.wr_data;
  assign bus.rd_data_a     = bus.mem_dout1;
  assign bus.rd_data_b     = bus.mem_dout2;
  assign bus.rd_data_valid = rd_data_valid_r;
  assign bus.rd_err        = rd_err_r;
  assign bus.rows_written  = rows_written_r;
  assign bus.frame_done    = (rows_written_r == ROWS_C);

endmodule
